cbl_microsequencer: RTL and testbench

//  Next-generation condition branch logic for the microprogrammed control unit.

---
 rtl/cbl_pkg.sv | 32 +++
 rtl/cbl_return_stack.sv | 68 ++++++
 rtl/cbl_microsequencer.sv | 131 +++++++++++++
 tb/tb_cbl_microsequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cbl_pkg.sv
// Shared definitions for the condition branch logic: COND encodings,
// control-store mux selects and PSR flag bit positions.
package cbl_pkg;

    // Microinstruction COND field encodings
    localparam logic [3:0] COND_NEXT     = 4'b0000;
    localparam logic [3:0] COND_JMP_N    = 4'b0001;
    localparam logic [3:0] COND_JMP_Z    = 4'b0010;
    localparam logic [3:0] COND_JMP_V    = 4'b0011;
    localparam logic [3:0] COND_JMP_C    = 4'b0100;
    localparam logic [3:0] COND_JMP_IR   = 4'b0101;
    localparam logic [3:0] COND_JMP      = 4'b0110;
    localparam logic [3:0] COND_DECODE   = 4'b0111;
    localparam logic [3:0] COND_CALL     = 4'b1000;
    localparam logic [3:0] COND_RET      = 4'b1001;
    localparam logic [3:0] COND_JMP_NZ   = 4'b1010;
    localparam logic [3:0] COND_JMP_NC   = 4'b1011;
    localparam logic [3:0] COND_JMP_NN   = 4'b1100;

    // Control-store address mux selects
    localparam logic [1:0] MUX_NEXT   = 2'b00;
    localparam logic [1:0] MUX_JUMP   = 2'b01;
    localparam logic [1:0] MUX_DECODE = 2'b10;
    localparam logic [1:0] MUX_RET    = 2'b11;

    // PSR flag positions within {N,Z,V,C}
    localparam int N_BIT = 3;
    localparam int Z_BIT = 2;
    localparam int V_BIT = 1;
    localparam int C_BIT = 0;

endpackage

// File: rtl/cbl_return_stack.sv
// LIFO of micro-subroutine return addresses. A push while full or a pop
// while empty is ignored here; the sequencer flags those cases itself.
module cbl_return_stack
    import cbl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 11,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LVL_W-1:0] level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [LVL_W-1:0] level_q;
    logic [LVL_W-1:0] level_d;
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             doPush;
    logic             doPop;

    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;

    // The occupancy count doubles as the write pointer; the top entry sits one below it
    assign wrPtr  = level_q[PTR_W-1:0];
    assign rdPtr  = level_q[PTR_W-1:0] - PTR_W'(1);
    assign data_o = mem_q[rdPtr];

    assign doPush = push_i && !full_o;
    assign doPop  = pop_i && !empty_o;

    // Next occupancy: grows on a push, shrinks on a pop
    always_comb begin
        level_d = level_q;
        if (doPush) begin
            level_d = level_q + LVL_W'(1);
        end else if (doPop) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    // Occupancy register; reset discards every stored return address
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    // Entry storage; contents above the occupancy count are don't-care
    always_ff @(posedge clk_i) begin
        if (doPush) begin
            mem_q[wrPtr] <= data_i;
        end
    end

endmodule

// File: rtl/cbl_microsequencer.sv
// Condition branch logic: decodes COND against PSR/IR, selects the next
// control-store address, owns the CS address register and the return stack.
module cbl_microsequencer
    import cbl_pkg::*;
#(
    parameter int                   ADDR_WIDTH  = 11,
    parameter int                   STACK_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic                         CLK,
    input  logic                         RESET_InLow,
    input  logic                         Stall_In,
    input  logic [3:0]                   PSR_In,
    input  logic [3:0]                   COND_In,
    input  logic                         IR_In,
    input  logic [ADDR_WIDTH-1:0]        JADDR_In,
    input  logic [ADDR_WIDTH-1:0]        DECODE_ADDR_In,
    output logic [ADDR_WIDTH-1:0]        CS_Addr_Out,
    output logic [1:0]                   Control_Branch_2_CS_MUX,
    output logic [$clog2(STACK_DEPTH):0] Stack_Level_Out,
    output logic                         Seq_Err_Out
);

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic                  err_q;
    logic                  err_d;
    logic [ADDR_WIDTH-1:0] nextAddr;
    logic [ADDR_WIDTH-1:0] retAddr;
    logic [1:0]            muxSel;
    logic                  holdAddr;
    logic                  errSet;
    logic                  pushReq;
    logic                  popReq;
    logic                  stackFull;
    logic                  stackEmpty;

    // Incrementer wraps naturally at the top of the control store
    assign nextAddr = addr_q + ADDR_WIDTH'(1);

    // Condition decode: chooses the mux source, stack operation and error case
    always_comb begin
        muxSel   = MUX_NEXT;
        holdAddr = 1'b0;
        errSet   = 1'b0;
        pushReq  = 1'b0;
        popReq   = 1'b0;
        case (COND_In)
            COND_NEXT:   muxSel = MUX_NEXT;
            COND_JMP_N:  muxSel = PSR_In[N_BIT] ? MUX_JUMP : MUX_NEXT;
            COND_JMP_Z:  muxSel = PSR_In[Z_BIT] ? MUX_JUMP : MUX_NEXT;
            COND_JMP_V:  muxSel = PSR_In[V_BIT] ? MUX_JUMP : MUX_NEXT;
            COND_JMP_C:  muxSel = PSR_In[C_BIT] ? MUX_JUMP : MUX_NEXT;
            COND_JMP_IR: muxSel = IR_In ? MUX_JUMP : MUX_NEXT;
            COND_JMP:    muxSel = MUX_JUMP;
            COND_DECODE: muxSel = MUX_DECODE;
            COND_CALL: begin
                if (stackFull) begin
                    holdAddr = 1'b1;
                    errSet   = 1'b1;
                end else begin
                    muxSel  = MUX_JUMP;
                    pushReq = 1'b1;
                end
            end
            COND_RET: begin
                if (stackEmpty) begin
                    holdAddr = 1'b1;
                    errSet   = 1'b1;
                end else begin
                    muxSel = MUX_RET;
                    popReq = 1'b1;
                end
            end
            COND_JMP_NZ: muxSel = PSR_In[Z_BIT] ? MUX_NEXT : MUX_JUMP;
            COND_JMP_NC: muxSel = PSR_In[C_BIT] ? MUX_NEXT : MUX_JUMP;
            COND_JMP_NN: muxSel = PSR_In[N_BIT] ? MUX_NEXT : MUX_JUMP;
            default: begin
                holdAddr = 1'b1;
                errSet   = 1'b1;
            end
        endcase
    end

    // Next-address mux; error cases keep the current address
    always_comb begin
        addr_d = nextAddr;
        if (holdAddr) begin
            addr_d = addr_q;
        end else begin
            case (muxSel)
                MUX_JUMP:   addr_d = JADDR_In;
                MUX_DECODE: addr_d = DECODE_ADDR_In;
                MUX_RET:    addr_d = retAddr;
                default:    addr_d = nextAddr;
            endcase
        end
        err_d = err_q | errSet;
    end

    // CS address and sticky error register; a stall freezes both
    always_ff @(posedge CLK or negedge RESET_InLow) begin
        if (!RESET_InLow) begin
            addr_q <= RESET_ADDR;
            err_q  <= 1'b0;
        end else if (!Stall_In) begin
            addr_q <= addr_d;
            err_q  <= err_d;
        end
    end

    cbl_return_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (ADDR_WIDTH)
    ) u_stack (
        .clk_i   (CLK),
        .rst_ni  (RESET_InLow),
        .push_i  (pushReq && !Stall_In),
        .pop_i   (popReq && !Stall_In),
        .data_i  (nextAddr),
        .data_o  (retAddr),
        .full_o  (stackFull),
        .empty_o (stackEmpty),
        .level_o (Stack_Level_Out)
    );

    assign CS_Addr_Out             = addr_q;
    assign Control_Branch_2_CS_MUX = muxSel;
    assign Seq_Err_Out             = err_q;

endmodule

// File: tb/tb_cbl_microsequencer.sv
// Directed self-checking bench for the condition branch logic.
module tb_cbl_microsequencer;

    logic        CLK;
    logic        RESET_InLow;
    logic        Stall_In;
    logic [3:0]  PSR_In;
    logic [3:0]  COND_In;
    logic        IR_In;
    logic [10:0] JADDR_In;
    logic [10:0] DECODE_ADDR_In;
    logic [10:0] CS_Addr_Out;
    logic [1:0]  Control_Branch_2_CS_MUX;
    logic [2:0]  Stack_Level_Out;
    logic        Seq_Err_Out;

    int checks;
    int errors;

    cbl_microsequencer #(
        .ADDR_WIDTH  (11),
        .STACK_DEPTH (4),
        .RESET_ADDR  (11'h000)
    ) dut (
        .CLK                     (CLK),
        .RESET_InLow             (RESET_InLow),
        .Stall_In                (Stall_In),
        .PSR_In                  (PSR_In),
        .COND_In                 (COND_In),
        .IR_In                   (IR_In),
        .JADDR_In                (JADDR_In),
        .DECODE_ADDR_In          (DECODE_ADDR_In),
        .CS_Addr_Out             (CS_Addr_Out),
        .Control_Branch_2_CS_MUX (Control_Branch_2_CS_MUX),
        .Stack_Level_Out         (Stack_Level_Out),
        .Seq_Err_Out             (Seq_Err_Out)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Present a microinstruction and let the decoder settle
    task automatic drive(input logic [3:0] cond, input logic [10:0] jaddr);
        COND_In  = cond;
        JADDR_In = jaddr;
        #1;
    endtask

    // Advance one rising edge and sample 1 time unit later
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Asynchronous reset pulse placed between clock edges
    task automatic pulseReset();
        #2;
        RESET_InLow = 1'b0;
        #1;
        RESET_InLow = 1'b1;
        COND_In     = 4'b0000;
        #1;
    endtask

    task automatic test_reset();
        drive(4'b1000, 11'h033);
        tick();
        if (CS_Addr_Out !== 11'h033) begin
            errors++;
            $display("[TB] FAIL reset_precall addr actual=%h required=%h", CS_Addr_Out, 11'h033);
        end
        checks++;
        #2;
        RESET_InLow = 1'b0;
        #1;
        if (CS_Addr_Out !== 11'h000) begin
            errors++;
            $display("[TB] FAIL reset_addr actual=%h required=%h", CS_Addr_Out, 11'h000);
        end
        checks++;
        if (Stack_Level_Out !== 3'd0) begin
            errors++;
            $display("[TB] FAIL reset_level actual=%0d required=0", Stack_Level_Out);
        end
        checks++;
        if (Seq_Err_Out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_err actual=%b required=0", Seq_Err_Out);
        end
        checks++;
        RESET_InLow = 1'b1;
        drive(4'b0000, 11'h000);
    endtask

    task automatic test_sequential();
        logic [10:0] expAddr [3];
        expAddr = '{11'h006, 11'h007, 11'h008};
        drive(4'b0110, 11'h005);
        tick();
        drive(4'b0000, 11'h000);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (CS_Addr_Out !== expAddr[i]) begin
                errors++;
                $display("[TB] FAIL seq_step%0d actual=%h required=%h", i, CS_Addr_Out, expAddr[i]);
            end
            checks++;
        end
        drive(4'b0110, 11'h7FF);
        tick();
        drive(4'b0000, 11'h000);
        if (Control_Branch_2_CS_MUX !== 2'b00) begin
            errors++;
            $display("[TB] FAIL seq_mux actual=%b required=00", Control_Branch_2_CS_MUX);
        end
        checks++;
        tick();
        if (CS_Addr_Out !== 11'h000) begin
            errors++;
            $display("[TB] FAIL seq_wrap actual=%h required=000", CS_Addr_Out);
        end
        checks++;
    endtask

    task automatic test_flag_branches();
        // psr, cond, ir, jaddr, required mux, required address (starting from prev)
        logic [3:0]  psrV  [7];
        logic [3:0]  condV [7];
        logic        irV   [7];
        logic [10:0] jV    [7];
        logic [1:0]  muxV  [7];
        logic [10:0] addrV [7];
        psrV  = '{4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0001};
        condV = '{4'b0010, 4'b1010, 4'b1011, 4'b0001, 4'b1100, 4'b0101, 4'b0100};
        irV   = '{1'b0,    1'b0,    1'b0,    1'b0,    1'b0,    1'b1,    1'b0};
        jV    = '{11'h040, 11'h200, 11'h120, 11'h300, 11'h050, 11'h3A0, 11'h0C0};
        muxV  = '{2'b01,   2'b00,   2'b01,   2'b01,   2'b00,   2'b01,   2'b01};
        addrV = '{11'h040, 11'h041, 11'h120, 11'h300, 11'h301, 11'h3A0, 11'h0C0};
        for (int i = 0; i < 7; i++) begin
            PSR_In = psrV[i];
            IR_In  = irV[i];
            drive(condV[i], jV[i]);
            if (Control_Branch_2_CS_MUX !== muxV[i]) begin
                errors++;
                $display("[TB] FAIL flag%0d_mux actual=%b required=%b", i, Control_Branch_2_CS_MUX, muxV[i]);
            end
            checks++;
            tick();
            if (CS_Addr_Out !== addrV[i]) begin
                errors++;
                $display("[TB] FAIL flag%0d_addr actual=%h required=%h", i, CS_Addr_Out, addrV[i]);
            end
            checks++;
        end
        PSR_In = 4'b0000;
        IR_In  = 1'b0;
        DECODE_ADDR_In = 11'h5A5;
        drive(4'b0111, 11'h000);
        if (Control_Branch_2_CS_MUX !== 2'b10) begin
            errors++;
            $display("[TB] FAIL decode_mux actual=%b required=10", Control_Branch_2_CS_MUX);
        end
        checks++;
        tick();
        if (CS_Addr_Out !== 11'h5A5) begin
            errors++;
            $display("[TB] FAIL decode_addr actual=%h required=5a5", CS_Addr_Out);
        end
        checks++;
    endtask

    task automatic test_call_return();
        drive(4'b0110, 11'h010);
        tick();
        drive(4'b1000, 11'h080);
        if (Control_Branch_2_CS_MUX !== 2'b01) begin
            errors++;
            $display("[TB] FAIL call_mux actual=%b required=01", Control_Branch_2_CS_MUX);
        end
        checks++;
        tick();
        if (CS_Addr_Out !== 11'h080 || Stack_Level_Out !== 3'd1) begin
            errors++;
            $display("[TB] FAIL call_state actual=%h/%0d required=080/1", CS_Addr_Out, Stack_Level_Out);
        end
        checks++;
        drive(4'b1001, 11'h000);
        if (Control_Branch_2_CS_MUX !== 2'b11) begin
            errors++;
            $display("[TB] FAIL ret_mux actual=%b required=11", Control_Branch_2_CS_MUX);
        end
        checks++;
        tick();
        if (CS_Addr_Out !== 11'h011 || Stack_Level_Out !== 3'd0) begin
            errors++;
            $display("[TB] FAIL ret_state actual=%h/%0d required=011/0", CS_Addr_Out, Stack_Level_Out);
        end
        checks++;
    endtask

    task automatic test_errors();
        logic [10:0] callTgt [4];
        logic [10:0] retExp  [4];
        callTgt = '{11'h200, 11'h300, 11'h400, 11'h500};
        retExp  = '{11'h401, 11'h301, 11'h201, 11'h101};
        drive(4'b0110, 11'h100);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(4'b1000, callTgt[i]);
            tick();
        end
        if (CS_Addr_Out !== 11'h500 || Stack_Level_Out !== 3'd4 || Seq_Err_Out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL nest4 actual=%h/%0d/%b required=500/4/0", CS_Addr_Out, Stack_Level_Out, Seq_Err_Out);
        end
        checks++;
        drive(4'b1000, 11'h600);
        tick();
        if (CS_Addr_Out !== 11'h500 || Stack_Level_Out !== 3'd4 || Seq_Err_Out !== 1'b1) begin
            errors++;
            $display("[TB] FAIL overflow actual=%h/%0d/%b required=500/4/1", CS_Addr_Out, Stack_Level_Out, Seq_Err_Out);
        end
        checks++;
        for (int i = 0; i < 4; i++) begin
            drive(4'b1001, 11'h000);
            tick();
            if (CS_Addr_Out !== retExp[i]) begin
                errors++;
                $display("[TB] FAIL unwind%0d actual=%h required=%h", i, CS_Addr_Out, retExp[i]);
            end
            checks++;
        end
        drive(4'b1001, 11'h000);
        if (Control_Branch_2_CS_MUX !== 2'b00) begin
            errors++;
            $display("[TB] FAIL underflow_mux actual=%b required=00", Control_Branch_2_CS_MUX);
        end
        checks++;
        tick();
        if (CS_Addr_Out !== 11'h101 || Stack_Level_Out !== 3'd0 || Seq_Err_Out !== 1'b1) begin
            errors++;
            $display("[TB] FAIL underflow actual=%h/%0d/%b required=101/0/1", CS_Addr_Out, Stack_Level_Out, Seq_Err_Out);
        end
        checks++;
        pulseReset();
        drive(4'b1001, 11'h000);
        tick();
        if (CS_Addr_Out !== 11'h000 || Seq_Err_Out !== 1'b1) begin
            errors++;
            $display("[TB] FAIL underflow_fresh actual=%h/%b required=000/1", CS_Addr_Out, Seq_Err_Out);
        end
        checks++;
        pulseReset();
        drive(4'b0110, 11'h0F0);
        tick();
        drive(4'b1110, 11'h222);
        if (Control_Branch_2_CS_MUX !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reserved_mux actual=%b required=00", Control_Branch_2_CS_MUX);
        end
        checks++;
        tick();
        if (CS_Addr_Out !== 11'h0F0 || Seq_Err_Out !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reserved actual=%h/%b required=0f0/1", CS_Addr_Out, Seq_Err_Out);
        end
        checks++;
        drive(4'b0000, 11'h000);
        tick();
        if (CS_Addr_Out !== 11'h0F1 || Seq_Err_Out !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sticky actual=%h/%b required=0f1/1", CS_Addr_Out, Seq_Err_Out);
        end
        checks++;
        pulseReset();
    endtask

    task automatic test_stall();
        drive(4'b0110, 11'h030);
        tick();
        Stall_In = 1'b1;
        drive(4'b0110, 11'h070);
        if (Control_Branch_2_CS_MUX !== 2'b01) begin
            errors++;
            $display("[TB] FAIL stall_mux actual=%b required=01", Control_Branch_2_CS_MUX);
        end
        checks++;
        tick();
        if (CS_Addr_Out !== 11'h030) begin
            errors++;
            $display("[TB] FAIL stall_hold actual=%h required=030", CS_Addr_Out);
        end
        checks++;
        drive(4'b1000, 11'h090);
        tick();
        if (CS_Addr_Out !== 11'h030 || Stack_Level_Out !== 3'd0) begin
            errors++;
            $display("[TB] FAIL stall_call actual=%h/%0d required=030/0", CS_Addr_Out, Stack_Level_Out);
        end
        checks++;
        drive(4'b1101, 11'h000);
        tick();
        if (Seq_Err_Out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_err actual=%b required=0", Seq_Err_Out);
        end
        checks++;
        drive(4'b0110, 11'h070);
        Stall_In = 1'b0;
        tick();
        if (CS_Addr_Out !== 11'h070) begin
            errors++;
            $display("[TB] FAIL stall_release actual=%h required=070", CS_Addr_Out);
        end
        checks++;
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        RESET_InLow    = 1'b0;
        Stall_In       = 1'b0;
        PSR_In         = 4'b0000;
        COND_In        = 4'b0000;
        IR_In          = 1'b0;
        JADDR_In       = 11'h000;
        DECODE_ADDR_In = 11'h000;
        #12;
        RESET_InLow = 1'b1;
        test_reset();
        test_sequential();
        test_flag_branches();
        test_call_return();
        test_errors();
        test_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
